// File: rtl/ripple_count_pkg.sv
// ripple_count_pkg
// Shared types and default parameters for the ripple count extender.
//   state_e       : extender FSM states (INIT, RUN, SAT)
//   *_DEF         : default IN_W / EXT_W / STABLE_CYCLES
//   STABLE_MAX    : largest supported STABLE_CYCLES, sizes the agree counter
package ripple_count_pkg;

  localparam int IN_W_DEF          = 4;
  localparam int EXT_W_DEF         = 16;
  localparam int STABLE_CYCLES_DEF = 2;
  localparam int STABLE_MAX        = 8;
  localparam int AGREE_W           = $clog2(STABLE_MAX + 1);

  typedef enum logic [1:0] {
    INIT = 2'd0,
    RUN  = 2'd1,
    SAT  = 2'd2
  } state_e;

endpackage

// File: rtl/count_stable_filter.sv
// count_stable_filter
// Re-samples the raw ripple counter and reports when one value has been seen
// on STABLE_CYCLES consecutive edges (legal range 2..STABLE_MAX).
// stable_o fires exactly once per run of identical samples, on the edge that
// completes the run; holding the value longer produces no further pulses.
//   clk_i, rst_i  : clock, async active-high reset
//   clear_i       : synchronous restart of the stability run; also masks stable_o
//   count_in_i    : raw ripple count
//   stable_o      : this edge completes a stable run
//   value_o       : the value of the current run
module count_stable_filter
  import ripple_count_pkg::*;
#(
  parameter int IN_W          = IN_W_DEF,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  input  logic [IN_W-1:0] count_in_i,
  output logic            stable_o,
  output logic [IN_W-1:0] value_o
);

  localparam logic [AGREE_W-1:0] AGREE_LAST = AGREE_W'(STABLE_CYCLES - 1);
  localparam logic [AGREE_W-1:0] AGREE_TOP  = AGREE_W'(STABLE_CYCLES);

  logic [IN_W-1:0]    samp_q, samp_d;
  logic [AGREE_W-1:0] agree_q, agree_d;
  logic               same;

  // agree_q counts samples of samp_q in the current run; 0 means no sample
  // yet, so a post-reset input that happens to equal 0 still needs a full run.
  assign same = (agree_q != '0) && (count_in_i == samp_q);

  always_comb begin
    samp_d  = count_in_i;
    agree_d = AGREE_W'(1);
    if (clear_i) begin
      samp_d  = '0;
      agree_d = '0;
    end else if (same) begin
      agree_d = (agree_q == AGREE_TOP) ? agree_q : agree_q + AGREE_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      samp_q  <= '0;
      agree_q <= '0;
    end else begin
      samp_q  <= samp_d;
      agree_q <= agree_d;
    end
  end

  assign stable_o = !clear_i && same && (agree_q == AGREE_LAST);
  assign value_o  = samp_q;

endmodule

// File: rtl/ripple_count_extender.sv
// ripple_count_extender
// Filters a glitchy ripple counter and extends it to a wide monotonic count.
// Optional build macro: RIPPLE_COUNT_SKIP_DETECT_EN enables skip_err_o
// (sticky flag for any RUN accept that is not exactly last+1).
//   clk_i, rst_i   : clock, async active-high reset
//   clear_i        : synchronous clear, same effect as reset
//   count_in_i     : raw ripple count (IN_W)
//   match_value_i  : threshold for match_pulse_o (EXT_W)
//   ext_count_o    : extended count (EXT_W)
//   ext_valid_o    : first stable value has been accepted
//   wrap_pulse_o   : one cycle per accepted wrap
//   match_pulse_o  : one cycle when ext_count_o changes to match_value_i
//   overflow_o     : sticky saturation flag
//   skip_err_o     : sticky skip flag (0 unless the macro is defined)
module ripple_count_extender
  import ripple_count_pkg::*;
#(
  parameter int IN_W          = IN_W_DEF,
  parameter int EXT_W         = EXT_W_DEF,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic [IN_W-1:0]  count_in_i,
  input  logic [EXT_W-1:0] match_value_i,
  output logic [EXT_W-1:0] ext_count_o,
  output logic             ext_valid_o,
  output logic             wrap_pulse_o,
  output logic             match_pulse_o,
  output logic             overflow_o,
  output logic             skip_err_o
);

  localparam int UP_W = EXT_W - IN_W;

  state_e           state_q, state_d;
  logic [EXT_W-1:0] ext_q, ext_d;
  logic             wrap_q, wrap_d;
  logic             match_q, match_d;
  logic             ovf_q, ovf_d;
  logic             stable;
  logic [IN_W-1:0]  value;
  logic [IN_W-1:0]  acc;
  logic [UP_W-1:0]  upper;

  count_stable_filter #(
    .IN_W          (IN_W),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (clear_i),
    .count_in_i (count_in_i),
    .stable_o   (stable),
    .value_o    (value)
  );

  // In RUN the low bits of the extended count always hold the last accepted
  // value, so no separate copy is kept.
  assign acc   = ext_q[IN_W-1:0];
  assign upper = ext_q[EXT_W-1:IN_W];

  always_comb begin
    state_d = state_q;
    ext_d   = ext_q;
    wrap_d  = 1'b0;
    ovf_d   = ovf_q;
    if (clear_i) begin
      state_d = INIT;
      ext_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          if (stable) begin
            ext_d   = {{UP_W{1'b0}}, value};
            state_d = RUN;
          end
        end
        RUN: begin
          if (stable && (value != acc)) begin
            if (value > acc) begin
              ext_d = {upper, value};
            end else if (&upper) begin
              ext_d   = '1;
              ovf_d   = 1'b1;
              state_d = SAT;
            end else begin
              ext_d  = {upper + UP_W'(1), value};
              wrap_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
    // Pulse only on a change of the count, never on a held value.
    match_d = !clear_i && (ext_d != ext_q) && (ext_d == match_value_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= INIT;
      ext_q   <= '0;
      wrap_q  <= 1'b0;
      match_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ext_q   <= ext_d;
      wrap_q  <= wrap_d;
      match_q <= match_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef RIPPLE_COUNT_SKIP_DETECT_EN
  logic skip_q, skip_d;

  always_comb begin
    skip_d = skip_q;
    if (clear_i) begin
      skip_d = 1'b0;
    end else if ((state_q == RUN) && stable && (value != acc) &&
                 (value != acc + IN_W'(1))) begin
      skip_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) skip_q <= 1'b0;
    else       skip_q <= skip_d;
  end

  assign skip_err_o = skip_q;
`else
  assign skip_err_o = 1'b0;
`endif

  assign ext_count_o   = ext_q;
  assign ext_valid_o   = (state_q != INIT);
  assign wrap_pulse_o  = wrap_q;
  assign match_pulse_o = match_q;
  assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_ripple_count_extender.sv
// tb_ripple_count_extender
// Two instances (EXT_W=16 and EXT_W=6) share one stimulus stream; a
// behavioural model tracks the stability run and each instance's total.
module tb_ripple_count_extender;

  localparam int SC = 2;
`ifdef RIPPLE_COUNT_SKIP_DETECT_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic [3:0]  count_in;
  logic [15:0] match_value;

  logic [15:0] ext_a;
  logic        valid_a, wrap_a, match_a, ovf_a, skip_a;
  logic [5:0]  ext_b;
  logic        valid_b, wrap_b, match_b, ovf_b, skip_b;

  always #5 clk = ~clk;

  ripple_count_extender #(.IN_W(4), .EXT_W(16), .STABLE_CYCLES(SC)) dut_a (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .count_in_i(count_in),
    .match_value_i(match_value), .ext_count_o(ext_a), .ext_valid_o(valid_a),
    .wrap_pulse_o(wrap_a), .match_pulse_o(match_a), .overflow_o(ovf_a),
    .skip_err_o(skip_a)
  );

  ripple_count_extender #(.IN_W(4), .EXT_W(6), .STABLE_CYCLES(SC)) dut_b (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .count_in_i(count_in),
    .match_value_i(match_value[5:0]), .ext_count_o(ext_b), .ext_valid_o(valid_b),
    .wrap_pulse_o(wrap_b), .match_pulse_o(match_b), .overflow_o(ovf_b),
    .skip_err_o(skip_b)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // model state: index 0 -> 16-bit instance, 1 -> 6-bit instance
  int run_val = 0;
  int run_len = 0;
  int ext_w   [2] = '{16, 6};
  int m_state [2];   // 0 waiting for first value, 1 counting, 2 saturated
  int m_ext   [2];
  int m_wrap  [2];
  int m_match [2];
  int m_ovf   [2];
  int m_skip  [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic void model_reset();
    run_len = 0;
    for (int i = 0; i < 2; i++) begin
      m_state[i] = 0; m_ext[i] = 0; m_wrap[i] = 0;
      m_match[i] = 0; m_ovf[i] = 0; m_skip[i] = 0;
    end
  endfunction

  function automatic void model_edge();
    bit st;
    int v, acc, lim, old;
    v = int'(count_in);
    if (clear) run_len = 0;
    else if (run_len > 0 && v == run_val) run_len++;
    else begin
      run_val = v;
      run_len = 1;
    end
    st = !clear && (run_len == SC);
    for (int i = 0; i < 2; i++) begin
      lim = (1 << ext_w[i]) - 1;
      old = m_ext[i];
      m_wrap[i] = 0;
      if (clear) begin
        m_state[i] = 0; m_ext[i] = 0; m_ovf[i] = 0; m_skip[i] = 0;
      end else if (st) begin
        acc = m_ext[i] % 16;
        if (m_state[i] == 0) begin
          m_ext[i] = v;
          m_state[i] = 1;
        end else if (m_state[i] == 1 && v != acc) begin
          if (SKIP_EN && v != (acc + 1) % 16) m_skip[i] = 1;
          if (v > acc) m_ext[i] = m_ext[i] - acc + v;
          else if ((m_ext[i] / 16) == (lim / 16)) begin
            m_ext[i] = lim;
            m_state[i] = 2;
            m_ovf[i] = 1;
          end else begin
            m_ext[i] = (m_ext[i] / 16 + 1) * 16 + v;
            m_wrap[i] = 1;
          end
        end
      end
      m_match[i] = (!clear && m_ext[i] != old && m_ext[i] == (int'(match_value) & lim)) ? 1 : 0;
    end
  endfunction

  task automatic check_all();
    chk("ext16",   32'(ext_a),   32'(m_ext[0]));
    chk("valid16", 32'(valid_a), 32'(m_state[0] != 0));
    chk("wrap16",  32'(wrap_a),  32'(m_wrap[0]));
    chk("match16", 32'(match_a), 32'(m_match[0]));
    chk("ovf16",   32'(ovf_a),   32'(m_ovf[0]));
    chk("skip16",  32'(skip_a),  32'(m_skip[0]));
    chk("ext6",    32'(ext_b),   32'(m_ext[1]));
    chk("valid6",  32'(valid_b), 32'(m_state[1] != 0));
    chk("wrap6",   32'(wrap_b),  32'(m_wrap[1]));
    chk("match6",  32'(match_b), 32'(m_match[1]));
    chk("ovf6",    32'(ovf_b),   32'(m_ovf[1]));
    chk("skip6",   32'(skip_b),  32'(m_skip[1]));
  endtask

  task automatic step(input int v, input bit clr);
    count_in = 4'(v);
    clear    = clr;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic hold(input int v, input int n);
    for (int k = 0; k < n; k++) step(v, 1'b0);
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("rst_ext16", 32'(ext_a), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cur, r;
    rst = 1'b1; clear = 1'b0; count_in = 4'd0; match_value = 16'h0012;
    model_reset();
    #3;
    chk("rst_ext16", 32'(ext_a), 32'd0);
    chk("rst_valid", 32'(valid_a), 32'd0);
    chk("rst_flags", 32'({wrap_a, match_a, ovf_a, skip_a}), 32'd0);
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // first value enters via INIT after two identical samples
    step(3, 0);
    chk("init_wait", 32'(valid_a), 32'd0);
    step(3, 0);
    chk("init_ext", 32'(ext_a), 32'd3);
    chk("init_valid", 32'(valid_a), 32'd1);
    chk("init_wrap", 32'(wrap_a), 32'd0);

    // glitch rejection
    hold(4, 2); hold(5, 2);
    step(7, 0);
    hold(6, 2);
    chk("glitch_ext", 32'(ext_a), 32'd6);
    chk("glitch_skip", 32'(skip_a), 32'd0);

    // wrap
    hold(13, 2); hold(14, 2); hold(15, 2);
    chk("pre_wrap", 32'(ext_a), 32'h000F);
    step(0, 0); step(0, 0);
    chk("wrap_ext", 32'(ext_a), 32'h0010);
    chk("wrap_pulse", 32'(wrap_a), 32'd1);
    step(1, 0);
    chk("wrap_once", 32'(wrap_a), 32'd0);
    step(1, 0);
    chk("post_wrap", 32'(ext_a), 32'h0011);

    // clear coincident with a wrap accept
    hold(14, 2); hold(15, 2);
    step(0, 0); step(0, 1);
    chk("clr_wrap", 32'(wrap_a), 32'd0);
    chk("clr_valid", 32'(valid_a), 32'd0);
    chk("clr_ext", 32'(ext_a), 32'd0);
    hold(2, 2);
    chk("clr_reinit", 32'(ext_a), 32'd2);

    // match and skip
    match_value = 16'h0012;
    hold(15, 2); hold(0, 2); hold(2, 2); hold(3, 2); hold(4, 2);

    // saturate the 6-bit instance
    for (int w = 0; w < 5; w++)
      for (int v = 0; v < 16; v++) hold(v, 2);
    chk("sat_ext6", 32'(ext_b), 32'h3F);
    chk("sat_ovf6", 32'(ovf_b), 32'd1);

    async_reset();
    hold(9, 3);

    // randomized traffic
    cur = 9;
    for (int it = 0; it < 2500; it++) begin
      r = $urandom_range(0, 999);
      if ($urandom_range(0, 3) == 0)
        match_value = 16'(m_ext[0] + $urandom_range(0, 3));
      else if ($urandom_range(0, 7) == 0)
        match_value = 16'($urandom);
      if (r < 20) begin
        step(cur, 1'b1);
      end else if (r < 23) begin
        async_reset();
      end else if (r < 80) begin
        cur = $urandom_range(0, 15);
        hold(cur, $urandom_range(1, 3));
      end else if (r < 140) begin
        step($urandom_range(0, 15), 1'b0);
      end else begin
        cur = (cur + 1) % 16;
        hold(cur, $urandom_range(1, 4));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
